// File: rtl/disp_page_sched.sv
// Page scheduler for the 8-digit display: maps two of four 16-bit sources onto the display halves.
// Optional timed rotation in AUTO is enabled by defining DISP_AUTO_ROTATE_EN.
module disp_page_sched #(
    parameter int unsigned HOLD_CYCLES = 200_000_000
) (
    input  logic        clk_100MHz_i,
    input  logic        rst_n,
    input  logic [63:0] src_val_i,
    input  logic [3:0]  src_upd_i,
    input  logic        btn_next_i,
    input  logic        freeze_i,
    output logic [15:0] cnt_val_1_o,
    output logic [15:0] cnt_val_2_o,
    output logic        page_o,
    output logic        pinned_o,
    output logic [3:0]  upd_flag_o
);

    localparam int unsigned CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_AUTO,
        S_PINNED,
        S_FROZEN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          page_q, page_d;
    logic          pend_q, pend_d;
    logic          pinned_q, pinned_d;
    logic [3:0]    flag_q, flag_d;
    logic [15:0]   val1_q, val1_d;
    logic [15:0]   val2_q, val2_d;

    logic          was_frozen;
    state_t        base_state;
    logic [CW-1:0] base_cnt;
    logic [CW-1:0] cnt_inc;
    logic          expiry;
    logic [3:0]    other_upd;
    logic [3:0]    clr_mask;

    // NOTE: every variable gets a default first, so no path through the decision tree can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        page_d   = page_q;
        pend_d   = pend_q;
        val1_d   = val1_q;
        val2_d   = val2_q;

        // Leaving FROZEN behaves like a fresh AUTO cycle with the counter at zero.
        was_frozen = (state_q == S_FROZEN);
        base_state = was_frozen ? S_AUTO : state_q;
        base_cnt   = was_frozen ? '0 : cnt_q;
        expiry     = (base_cnt == CNT_LAST);
        cnt_inc    = expiry ? '0 : base_cnt + CW'(1);

        // Only updates for the page not currently shown are of interest.
        other_upd = page_q ? {2'b00, src_upd_i[1:0]} : {src_upd_i[3:2], 2'b00};

        if (freeze_i) begin
            state_d = S_FROZEN;
        end else begin
            state_d = base_state;
            cnt_d   = was_frozen ? '0 : cnt_inc;
            pend_d  = was_frozen ? 1'b0 : pend_q;

            if (btn_next_i) begin
                page_d  = ~page_q;
                cnt_d   = '0;
                state_d = S_AUTO;
                pend_d  = 1'b0;
            end else if (|other_upd) begin
                if (base_state == S_AUTO) begin
                    page_d  = ~page_q;
                    cnt_d   = '0;
                    state_d = S_PINNED;
                    pend_d  = 1'b0;
                end else begin
                    pend_d = 1'b1;
                end
            end else if (base_state == S_PINNED) begin
                if (expiry) begin
                    if (pend_q) begin
                        page_d = ~page_q;
                        pend_d = 1'b0;
                    end else begin
                        state_d = S_AUTO;
                    end
                end
            end else begin
`ifdef DISP_AUTO_ROTATE_EN
                if (expiry) begin
                    page_d = ~page_q;
                end
`else
                cnt_d = '0;
`endif
            end

            val1_d = page_d ? src_val_i[47:32] : src_val_i[15:0];
            val2_d = page_d ? src_val_i[63:48] : src_val_i[31:16];
        end

        pinned_d = (state_d == S_PINNED);

        // A source that becomes visible this cycle loses its flag even if it was set this cycle.
        clr_mask = '0;
        if (page_d != page_q) begin
            clr_mask = page_d ? 4'b1100 : 4'b0011;
        end
        flag_d = (flag_q | other_upd) & ~clr_mask;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_AUTO;
            cnt_q    <= '0;
            page_q   <= 1'b0;
            pend_q   <= 1'b0;
            pinned_q <= 1'b0;
            flag_q   <= '0;
            val1_q   <= '0;
            val2_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            page_q   <= page_d;
            pend_q   <= pend_d;
            pinned_q <= pinned_d;
            flag_q   <= flag_d;
            val1_q   <= val1_d;
            val2_q   <= val2_d;
        end
    end

    assign cnt_val_1_o = val1_q;
    assign cnt_val_2_o = val2_q;
    assign page_o      = page_q;
    assign pinned_o    = pinned_q;
    assign upd_flag_o  = flag_q;

endmodule

// File: tb/tb_disp_page_sched.sv
// Directed bench for disp_page_sched with HOLD_CYCLES=8; rotation checks follow DISP_AUTO_ROTATE_EN.
module tb_disp_page_sched;

    logic        clk_100MHz_i;
    logic        rst_n;
    logic [63:0] src_val_i;
    logic [3:0]  src_upd_i;
    logic        btn_next_i;
    logic        freeze_i;
    logic [15:0] cnt_val_1_o;
    logic [15:0] cnt_val_2_o;
    logic        page_o;
    logic        pinned_o;
    logic [3:0]  upd_flag_o;

    int n_checks = 0;
    int n_errors = 0;

    disp_page_sched #(.HOLD_CYCLES(8)) dut (
        .clk_100MHz_i (clk_100MHz_i),
        .rst_n        (rst_n),
        .src_val_i    (src_val_i),
        .src_upd_i    (src_upd_i),
        .btn_next_i   (btn_next_i),
        .freeze_i     (freeze_i),
        .cnt_val_1_o  (cnt_val_1_o),
        .cnt_val_2_o  (cnt_val_2_o),
        .page_o       (page_o),
        .pinned_o     (pinned_o),
        .upd_flag_o   (upd_flag_o)
    );

    initial clk_100MHz_i = 1'b0;
    always #5 clk_100MHz_i = ~clk_100MHz_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] v1, input logic [15:0] v2,
                             input logic pg, input logic pin, input logic [3:0] flg);
        check({tag, ".val1"},   64'(cnt_val_1_o), 64'(v1));
        check({tag, ".val2"},   64'(cnt_val_2_o), 64'(v2));
        check({tag, ".page"},   64'(page_o),      64'(pg));
        check({tag, ".pinned"}, 64'(pinned_o),    64'(pin));
        check({tag, ".flags"},  64'(upd_flag_o),  64'(flg));
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_100MHz_i);
        #1;
    endtask

    initial begin
        rst_n      = 1'b1;
        src_val_i  = 64'h4444_3333_2222_1111;
        src_upd_i  = 4'b0000;
        btn_next_i = 1'b0;
        freeze_i   = 1'b0;
        #3 rst_n = 1'b0;
        #3;
        check_all("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000);
        @(negedge clk_100MHz_i);
        rst_n = 1'b1;
        step(1);
        check_all("first_load", 16'h1111, 16'h2222, 1'b0, 1'b0, 4'b0000);

`ifdef DISP_AUTO_ROTATE_EN
        step(7);
        check_all("rot_8", 16'h3333, 16'h4444, 1'b1, 1'b0, 4'b0000);
        step(8);
        check_all("rot_16", 16'h1111, 16'h2222, 1'b0, 1'b0, 4'b0000);
`else
        step(40);
        check_all("idle_40", 16'h1111, 16'h2222, 1'b0, 1'b0, 4'b0000);
`endif

        // Jump on update to the other page, then PINNED lasts one dwell period.
        src_upd_i = 4'b0100;
        step(1);
        src_upd_i = 4'b0000;
        check_all("jump", 16'h3333, 16'h4444, 1'b1, 1'b1, 4'b0000);
        step(7);
        check("pinned_hold", 64'(pinned_o), 64'd1);
        step(1);
        check_all("pinned_end", 16'h3333, 16'h4444, 1'b1, 1'b0, 4'b0000);

        // Back to page 0, then jump into PINNED on page 1.
        btn_next_i = 1'b1;
        step(1);
        btn_next_i = 1'b0;
        check_all("btn_back", 16'h1111, 16'h2222, 1'b0, 1'b0, 4'b0000);
        src_upd_i = 4'b0100;
        step(1);
        src_upd_i = 4'b0000;
        check_all("jump2", 16'h3333, 16'h4444, 1'b1, 1'b1, 4'b0000);

        // Pending jump recorded at count 3, taken at expiry.
        step(3);
        src_upd_i = 4'b0001;
        step(1);
        src_upd_i = 4'b0000;
        check_all("pend_set", 16'h3333, 16'h4444, 1'b1, 1'b1, 4'b0001);
        step(3);
        check("pend_wait.page", 64'(page_o), 64'd1);
        step(1);
        check_all("pend_jump", 16'h1111, 16'h2222, 1'b0, 1'b1, 4'b0000);

        // btn and update in the same cycle: btn wins, flag of the shown source clears.
        btn_next_i = 1'b1;
        src_upd_i  = 4'b1000;
        step(1);
        btn_next_i = 1'b0;
        src_upd_i  = 4'b0000;
        check_all("btn_upd", 16'h3333, 16'h4444, 1'b1, 1'b0, 4'b0000);
`ifdef DISP_AUTO_ROTATE_EN
        step(7);
        check("btn_cnt0_hold.page", 64'(page_o), 64'd1);
        step(1);
        check_all("btn_cnt0_rot", 16'h1111, 16'h2222, 1'b0, 1'b0, 4'b0000);
`else
        btn_next_i = 1'b1;
        step(1);
        btn_next_i = 1'b0;
        check_all("btn_back2", 16'h1111, 16'h2222, 1'b0, 1'b0, 4'b0000);
`endif

        // Freeze for 20 cycles while sources change; flags keep setting.
        freeze_i  = 1'b1;
        src_val_i = 64'hAAAA_BBBB_CCCC_DDDD;
        src_upd_i = 4'b0100;
        step(1);
        src_upd_i = 4'b0000;
        step(19);
        check_all("frozen", 16'h1111, 16'h2222, 1'b0, 1'b0, 4'b0100);
        freeze_i = 1'b0;
        step(1);
        check_all("unfreeze", 16'hDDDD, 16'hCCCC, 1'b0, 1'b0, 4'b0100);
`ifdef DISP_AUTO_ROTATE_EN
        step(7);
        check("unfreeze_cnt0.page", 64'(page_o), 64'd0);
        step(1);
        check_all("unfreeze_rot", 16'hBBBB, 16'hAAAA, 1'b1, 1'b0, 4'b0000);
`else
        btn_next_i = 1'b1;
        step(1);
        btn_next_i = 1'b0;
        check_all("unfreeze_btn", 16'hBBBB, 16'hAAAA, 1'b1, 1'b0, 4'b0000);
`endif

        // Asynchronous reset in the middle of PINNED.
        src_upd_i = 4'b0001;
        step(1);
        src_upd_i = 4'b0000;
        check_all("jump3", 16'hDDDD, 16'hCCCC, 1'b0, 1'b1, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
